// File: rtl/ycbcr2rgb_pipe.sv
// ycbcr2rgb_pipe: full-range BT.601 YCbCr -> RGB, 3-stage valid/ready pipeline.
// Constant multiplies are Q16 shift-add trees. Sideband (SOF/EOL) rides with each
// pixel, and a saturating counter tracks how many pixels of the frame were clamped.
module ycbcr2rgb_pipe #(
  parameter int CLIP_CNT_W = 16,
  parameter bit ROUND_EN   = 1'b1
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic [7:0]            iY,
  input  logic [7:0]            iCb,
  input  logic [7:0]            iCr,
  input  logic                  iSof,
  input  logic                  iEol,
  input  logic                  iValid,
  output logic                  oReady,
  output logic [7:0]            oR,
  output logic [7:0]            oG,
  output logic [7:0]            oB,
  output logic                  oSof,
  output logic                  oEol,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [CLIP_CNT_W-1:0] oClipCnt
);

  localparam int STAGES = 3;

  // Q16 coefficients (all fit in 17 unsigned bits)
  localparam logic [16:0] KR  = 17'd91881;
  localparam logic [16:0] KGB = 17'd22553;
  localparam logic [16:0] KGR = 17'd46802;
  localparam logic [16:0] KB  = 17'd116130;

  localparam logic signed [26:0] RND = ROUND_EN ? 27'sd32768 : 27'sd0;

  typedef struct packed {
    logic sof;
    logic eol;
  } sb_t;

  // constant multiply as a shift-add over the set bits of k; 26b holds 116130*|-128|
  function automatic logic signed [25:0] kmul(input logic signed [8:0] d,
                                               input logic [16:0] k);
    logic signed [25:0] dx;
    logic signed [25:0] acc;
    dx  = {{17{d[8]}}, d};
    acc = '0;
    for (int i = 0; i < 17; i++)
      if (k[i]) acc = acc + (dx <<< i);
    return acc;
  endfunction

  // arithmetic >>16 then clamp to [0,255]; bit 8 flags that clamping happened
  function automatic logic [8:0] clamp8(input logic signed [26:0] s);
    logic signed [26:0] sh;
    sh = s >>> 16;
    if (sh < 27'sd0)   return 9'h100;
    if (sh > 27'sd255) return 9'h1FF;
    return {1'b0, sh[7:0]};
  endfunction

  logic en;
  assign en     = ~oValid | iReady;
  assign oReady = en;

  logic [STAGES:1] vld_pipe;
  sb_t  [STAGES:1] sb_pipe;

  // stage 1: centred chroma
  logic [7:0]        s1_y;
  logic signed [8:0] s1_dcb, s1_dcr;

  // stage 2: products and scaled luma
  logic [7:0]         s2_y;
  logic signed [25:0] s2_pr, s2_pgb, s2_pgr, s2_pb;

  // stage 3: clamped result and clip flag
  logic [2:0][7:0] rgb;
  logic            s3_clip;

  // valid and sideband shift together; everything holds while en is low
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      vld_pipe <= '0;
      sb_pipe  <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], iValid};
      sb_pipe  <= {sb_pipe[STAGES-1:1], sb_t'{sof: iSof, eol: iEol}};
    end
  end

  // S1 and S2 datapath registers (bubbles flow through with valid=0)
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      s1_y   <= '0;
      s1_dcb <= '0;
      s1_dcr <= '0;
      s2_y   <= '0;
      s2_pr  <= '0;
      s2_pgb <= '0;
      s2_pgr <= '0;
      s2_pb  <= '0;
    end else if (en) begin
      s1_y   <= iY;
      s1_dcb <= $signed({1'b0, iCb}) - 9'sd128;
      s1_dcr <= $signed({1'b0, iCr}) - 9'sd128;
      s2_y   <= s1_y;
      s2_pr  <= kmul(s1_dcr, KR);
      s2_pgb <= kmul(s1_dcb, KGB);
      s2_pgr <= kmul(s1_dcr, KGR);
      s2_pb  <= kmul(s1_dcb, KB);
    end
  end

  // S3 combinational sums, index 2=R 1=G 0=B
  logic signed [26:0] yq;
  logic signed [26:0] sum [3];
  logic [2:0][7:0]    val;
  logic [2:0]         clp;

  assign yq     = $signed({3'b000, s2_y, 16'h0000});
  assign sum[2] = yq + 27'(s2_pr) + RND;
  assign sum[1] = yq - 27'(s2_pgb) - 27'(s2_pgr) + RND;
  assign sum[0] = yq + 27'(s2_pb) + RND;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign {clp[c], val[c]} = clamp8(sum[c]);
  end

  // S3 output registers
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      rgb     <= '0;
      s3_clip <= 1'b0;
    end else if (en) begin
      rgb     <= val;
      s3_clip <= |clp;
    end
  end

  assign oR     = rgb[2];
  assign oG     = rgb[1];
  assign oB     = rgb[0];
  assign oValid = vld_pipe[STAGES];
  assign oSof   = sb_pipe[STAGES].sof;
  assign oEol   = sb_pipe[STAGES].eol;

  // per-frame clip counter: SOF beat restarts at 0/1, otherwise saturating increment
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      oClipCnt <= '0;
    end else if (oValid && iReady) begin
      if (oSof)
        oClipCnt <= CLIP_CNT_W'(s3_clip);
      else if (s3_clip && (oClipCnt != '1))
        oClipCnt <= oClipCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// Directed bench for ycbcr2rgb_pipe: hand-computed vector table, expected-beat queue
// checked on the falling edge, stall/hold, reset flush and clip-counter saturation.
module tb_ycbcr2rgb_pipe;

  localparam int CW = 8;
  localparam logic [CW-1:0] CMAX = '1;

  logic          iClk = 1'b0;
  logic          iReset_n;
  logic [7:0]    iY, iCb, iCr;
  logic          iSof, iEol, iValid, iReady;
  logic          oReady, oSof, oEol, oValid;
  logic [7:0]    oR, oG, oB;
  logic [CW-1:0] oClipCnt;

  logic          t_ready, t_sof, t_eol, t_valid;
  logic [7:0]    t_r, t_g, t_b;
  logic [15:0]   t_cnt;

  always #5 iClk = ~iClk;

  ycbcr2rgb_pipe #(.CLIP_CNT_W(CW), .ROUND_EN(1'b1)) u_dut (
    .iClk(iClk), .iReset_n(iReset_n), .iY(iY), .iCb(iCb), .iCr(iCr),
    .iSof(iSof), .iEol(iEol), .iValid(iValid), .oReady(oReady),
    .oR(oR), .oG(oG), .oB(oB), .oSof(oSof), .oEol(oEol), .oValid(oValid),
    .iReady(iReady), .oClipCnt(oClipCnt));

  ycbcr2rgb_pipe #(.CLIP_CNT_W(16), .ROUND_EN(1'b0)) u_dut_t (
    .iClk(iClk), .iReset_n(iReset_n), .iY(iY), .iCb(iCb), .iCr(iCr),
    .iSof(iSof), .iEol(iEol), .iValid(iValid), .oReady(t_ready),
    .oR(t_r), .oG(t_g), .oB(t_b), .oSof(t_sof), .oEol(t_eol), .oValid(t_valid),
    .iReady(iReady), .oClipCnt(t_cnt));

  typedef struct {
    logic [7:0] y, cb, cr;
    logic [7:0] r, g, b;     // rounded
    logic [7:0] rt, gt, bt;  // truncated
    logic       clip;        // rounded build clamps
  } vec_t;

  typedef struct {
    int   idx;
    logic sof, eol;
  } exp_t;

  // hand-computed vectors
  function automatic vec_t vec(input int i);
    vec_t v;
    case (i)
      0:       v = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 1'b0};
      1:       v = '{8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0,   8'd254, 8'd0,   8'd0,   1'b0};
      2:       v = '{8'd0,   8'd128, 8'd0,   8'd0,   8'd91,  8'd0,   8'd0,   8'd91,  8'd0,   1'b1};
      3:       v = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255, 8'd255, 8'd164, 8'd255, 1'b1};
      4:       v = '{8'd0,   8'd0,   8'd128, 8'd0,   8'd44,  8'd0,   8'd0,   8'd44,  8'd0,   1'b1};
      5:       v = '{8'd255, 8'd255, 8'd128, 8'd255, 8'd211, 8'd255, 8'd255, 8'd211, 8'd255, 1'b1};
      default: v = '{8'd100, 8'd150, 8'd90,  8'd47,  8'd120, 8'd139, 8'd46,  8'd119, 8'd138, 1'b0};
    endcase
    return v;
  endfunction

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  exp_t          q[$];
  logic [CW-1:0] exp_cnt = '0;
  logic          mon_en  = 1'b0;
  logic          held    = 1'b0;
  logic [7:0]    snap_r, snap_g, snap_b;

  // falling-edge monitor: counter, hold during stall, and beat contents
  always @(negedge iClk) begin
    if (mon_en) begin
      exp_t e;
      vec_t v;
      chk("clip_cnt", oClipCnt, exp_cnt);
      if (held) begin
        chk("hold_r", oR, snap_r);
        chk("hold_g", oG, snap_g);
        chk("hold_b", oB, snap_b);
        chk("hold_valid", oValid, 1);
      end
      if (oValid && !iReady) begin
        chk("stall_ready", oReady, 0);
        held   = 1'b1;
        snap_r = oR;
        snap_g = oG;
        snap_b = oB;
      end else begin
        held = 1'b0;
      end
      if (oValid && iReady) begin
        if (q.size() == 0) begin
          chk("extra_beat", oValid, 0);
        end else begin
          e = q.pop_front();
          v = vec(e.idx);
          chk("r", oR, v.r);
          chk("g", oG, v.g);
          chk("b", oB, v.b);
          chk("sof", oSof, e.sof);
          chk("eol", oEol, e.eol);
          chk("trunc_valid", t_valid, 1);
          chk("trunc_r", t_r, v.rt);
          chk("trunc_g", t_g, v.gt);
          chk("trunc_b", t_b, v.bt);
          if (e.sof)                          exp_cnt = CW'(v.clip);
          else if (v.clip && exp_cnt != CMAX) exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
  end

  // present one pixel and hold it until accepted
  task automatic send_px(input int idx, input logic sof, input logic eol);
    vec_t v;
    logic acc;
    exp_t e;
    v      = vec(idx);
    iY     = v.y;
    iCb    = v.cb;
    iCr    = v.cr;
    iSof   = sof;
    iEol   = eol;
    iValid = 1'b1;
    acc    = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge iClk);
      acc = oReady;
      @(posedge iClk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", acc, 1);
    e.idx = idx;
    e.sof = sof;
    e.eol = eol;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    iValid = 1'b0;
    repeat (n) @(posedge iClk);
    #1;
  endtask

  initial begin
    int k;
    iReset_n = 1'b0;
    iReady   = 1'b1;
    iValid   = 1'b0;
    iY = '0; iCb = '0; iCr = '0; iSof = 1'b0; iEol = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_valid", oValid, 0);
    chk("rst_r", oR, 0);
    chk("rst_g", oG, 0);
    chk("rst_b", oB, 0);
    chk("rst_sof", oSof, 0);
    chk("rst_eol", oEol, 0);
    chk("rst_cnt", oClipCnt, 0);
    chk("rst_ready", oReady, 1);
    iReset_n = 1'b1;
    mon_en   = 1'b1;

    // mid-grey, 3-cycle latency
    send_px(0, 1'b1, 1'b0);
    iValid = 1'b0;
    k = 0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge iClk);
      if (oValid) begin
        k = t;
        break;
      end
    end
    chk("latency", k, 3);
    idle(3);

    // remaining vectors back to back
    for (int i = 1; i < 7; i++) send_px(i, 1'b0, i == 6);
    idle(5);

    // 10-pixel stream with a bubble and a 4-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          if (i == 6) idle(1);
          send_px(i % 7, i == 0, (i == 4) || (i == 9));
        end
        iValid = 1'b0;
      end
      begin
        repeat (4) @(posedge iClk);
        #1 iReady = 1'b0;
        repeat (4) @(posedge iClk);
        #1 iReady = 1'b1;
      end
    join
    idle(6);
    chk("stream_drained", q.size(), 0);

    // saturation: one frame of 2^CW+5 clipping pixels
    send_px(3, 1'b1, 1'b0);
    for (int i = 1; i < (1 << CW) + 5; i++) send_px(3, 1'b0, 1'b0);
    idle(5);
    chk("sat", oClipCnt, CMAX);
    send_px(0, 1'b1, 1'b0);
    idle(5);
    chk("sof_reload0", oClipCnt, 0);
    send_px(3, 1'b1, 1'b1);
    idle(5);
    chk("sof_reload1", oClipCnt, 1);

    // reset with three pixels in flight
    send_px(3, 1'b0, 1'b0);
    send_px(2, 1'b0, 1'b0);
    send_px(5, 1'b0, 1'b1);
    mon_en   = 1'b0;
    iValid   = 1'b0;
    iReset_n = 1'b0;
    @(posedge iClk);
    #1;
    chk("flush_valid", oValid, 0);
    chk("flush_cnt", oClipCnt, 0);
    chk("flush_r", oR, 0);
    chk("flush_eol", oEol, 0);
    iReset_n = 1'b1;
    q.delete();
    exp_cnt = '0;
    for (int t = 0; t < 5; t++) begin
      @(negedge iClk);
      chk("post_flush_valid", oValid, 0);
    end
    @(posedge iClk);
    #1 mon_en = 1'b1;

    // pipeline still works after flush
    send_px(6, 1'b1, 1'b1);
    idle(5);
    chk("final_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
